alu_word_sequencer: RTL and testbench
=====================================

Name: alu_word_sequencer

Overview:
- Multi-word operation sequencer that sits directly around the 16-bit ALU.
- Accepts up to WORDS x 16-bit operands and drives the ALU one 16-bit word per cycle, least-significant word first.
- Captures each word result and chains carry/borrow between words.
- Delivers the wide result, a final carry/borrow flag, a whole-result zero flag and a done pulse to the control path.

Parameters:
- WORDS, 4, maximum operand width in 16-bit words (legal range 1..16).
- DATA_W, 16, ALU word width; fixed, not to be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  start request; accepted only in IDLE.
- op_a  input  WORDS*16  operand A, word 0 = bits [15:0].
- op_b  input  WORDS*16  operand B.
- op_select  input  4  ALU select code for the whole operation.
- op_mode  input  1  0 = arithmetic unit, 1 = logic unit.
- op_cin  input  1  initial carry (add) or borrow (sub) into word 0.
- num_words  input  $clog2(WORDS+1)  words to process.
- alu_in_a  output  16  word to ALU in_a.
- alu_in_b  output  16  word to ALU in_b.
- alu_carry_in  output  1  to ALU carry_in.
- alu_select  output  4  to ALU select.
- alu_mode  output  1  to ALU mode.
- alu_result  input  16  from ALU alu_out (combinational, same cycle).
- busy  output  1  high from the start-accept edge until DONE exits.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  WORDS*16  assembled result.
- carry_flag  output  1  final carry (add) or borrow (sub), else 0.
- zero_flag  output  1  1 when every processed result word is 0.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, carry_flag, zero_flag = 0; result = 0; all alu_* outputs = 0; word index = 0. Reset mid-operation aborts it and emits no done pulse.
- Capture: start in IDLE latches op_a, op_b, op_select, op_mode and op_cin. It also latches the effective word count N: num_words = 0 is treated as 1, and num_words > WORDS is clamped to WORDS. At the same edge, result is cleared, the chain carry is set to op_cin, zero accumulator = 1, and the state moves to RUN.
- start while busy is ignored. No queuing.
- RUN, cycle k (k = 0..N-1): alu_in_a/alu_in_b = latched word k; alu_select/alu_mode = latched op; alu_carry_in = chain carry.
- At each RUN edge: result word k <= alu_result; zero accumulator &= (alu_result == 0); chain carry updated; k++.
- Chain carry is generated locally, and ALU carry_out/compare are not used:
  - add (mode 0, select 0000): next carry = bit 16 of ({1'b0,a_k} + b_k + carry).
  - sub (mode 0, select 0001): next borrow = (a_k < b_k) or (a_k == b_k and borrow).
  - all other ops: alu_carry_in = 0 and chain carry = 0.
- Shifts (mode 0, select 1001/1010) are per-word only, with no inter-word bit propagation.
- After the edge capturing word N-1, the state moves to DONE. In DONE, done = 1 for exactly one cycle, carry_flag = final chain carry, zero_flag = accumulator. Then the state returns to IDLE.
- Latency: with start accepted at edge E, done is high in the cycle after edge E+N (N+1 cycles after start).
- result, carry_flag and zero_flag hold until the next accepted start. Words at index >= N read 0.
- In IDLE and DONE, the alu_* outputs are 0.
- A start asserted during the DONE cycle is ignored; it is accepted in IDLE on the next cycle if still high.

Decomposition:
- Package alu_pkg holds:
  - select encodings SEL_ADD=0000, SEL_SUB=0001, SEL_AND=0010, SEL_OR=0011, SEL_XOR=0100, SEL_NOTA=0101, SEL_NOTB=0110, SEL_PASSA=0111, SEL_PASSB=1000, SEL_SHL=1001, SEL_SHR=1010;
  - MODE_ARITH=0, MODE_LOGIC=1;
  - WORD_W=16;
  - state enum {IDLE, RUN, DONE}.
- One sub-module, alu_chain_carry: combinational next carry/borrow from a_k, b_k, carry, op.
- The ALU itself is instantiated in the bench/top, not inside this block.

Test Plan:
- add, N=2, A=0x0000FFFF, B=0x00000001, cin=0 -> result 0x00010000, carry_flag 0, zero_flag 0, done 3 cycles after start edge, busy high 3 cycles.
- add, N=2, A=0xFFFFFFFF, B=0x00000001 -> result 0x00000000, carry_flag 1, zero_flag 1.
- sub, N=2, A=0x00010000, B=0x00000001 -> 0x0000FFFF, carry_flag 0; then A=0, B=1 -> 0xFFFFFFFF, carry_flag 1.
- logic AND, mode 1 select 0000, N=4, A=0xF0F0..., B=0xFFFF0000FFFF0000 -> word-wise AND, carry_flag 0, alu_carry_in 0 every cycle.
- start held high through the operation, plus num_words=0 and num_words=WORDS+1 -> single operation only; N=1 and N=WORDS respectively.
- rst_n low during RUN word 1 -> all outputs 0 immediately, no done pulse, next start processes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings, sequencer state type and op classification helpers.
package alu_pkg;

    localparam int WORD_W = 16;

    localparam logic [3:0] SEL_ADD   = 4'b0000;
    localparam logic [3:0] SEL_SUB   = 4'b0001;
    localparam logic [3:0] SEL_AND   = 4'b0010;
    localparam logic [3:0] SEL_OR    = 4'b0011;
    localparam logic [3:0] SEL_XOR   = 4'b0100;
    localparam logic [3:0] SEL_NOTA  = 4'b0101;
    localparam logic [3:0] SEL_NOTB  = 4'b0110;
    localparam logic [3:0] SEL_PASSA = 4'b0111;
    localparam logic [3:0] SEL_PASSB = 4'b1000;
    localparam logic [3:0] SEL_SHL   = 4'b1001;
    localparam logic [3:0] SEL_SHR   = 4'b1010;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Operation as latched for the whole multi-word sequence
    typedef struct packed {
        logic [3:0] sel;
        logic       mode;
    } alu_op_t;

    function automatic logic is_add(input alu_op_t op);
        return (op.mode == MODE_ARITH) && (op.sel == SEL_ADD);
    endfunction

    function automatic logic is_sub(input alu_op_t op);
        return (op.mode == MODE_ARITH) && (op.sel == SEL_SUB);
    endfunction

    // Only add and sub carry anything between words; shifts stay per-word
    function automatic logic is_chain(input alu_op_t op);
        return is_add(op) || is_sub(op);
    endfunction

endpackage

// File: rtl/alu_chain_carry.sv
// Next inter-word carry (add) or borrow (sub), computed locally so the
// ALU's own carry_out/compare outputs are never needed.
module alu_chain_carry
    import alu_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              carry,
    input  alu_op_t           op,
    output logic              carry_nxt
);

    logic [WORD_W:0] sum;

    // Carry out of bit 15 for add, borrow rule for sub, zero otherwise
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, carry};
        carry_nxt = 1'b0;
        if (is_add(op))
            carry_nxt = sum[WORD_W];
        else if (is_sub(op))
            carry_nxt = (a < b) || ((a == b) && carry);
    end

endmodule

// File: rtl/alu_word_sequencer.sv
// Drives a 16-bit ALU one word per cycle (LSW first), chaining carry/borrow
// and assembling the wide result plus final carry and zero flags.
module alu_word_sequencer
    import alu_pkg::*;
#(
    parameter int WORDS  = 4,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WORDS*DATA_W-1:0]    op_a,
    input  logic [WORDS*DATA_W-1:0]    op_b,
    input  logic [3:0]                 op_select,
    input  logic                       op_mode,
    input  logic                       op_cin,
    input  logic [$clog2(WORDS+1)-1:0] num_words,
    output logic [DATA_W-1:0]          alu_in_a,
    output logic [DATA_W-1:0]          alu_in_b,
    output logic                       alu_carry_in,
    output logic [3:0]                 alu_select,
    output logic                       alu_mode,
    input  logic [DATA_W-1:0]          alu_result,
    output logic                       busy,
    output logic                       done,
    output logic [WORDS*DATA_W-1:0]    result,
    output logic                       carry_flag,
    output logic                       zero_flag
);

    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef logic [WORDS-1:0][WORD_W-1:0] word_vec_t;

    state_t            state, state_nxt;
    word_vec_t         a_q, b_q, res_q;
    alu_op_t           op_q, op_in;
    logic [CNT_W-1:0]  n_q, n_eff;
    logic [IDX_W-1:0]  idx_q;
    logic              carry_q, zacc_q, carry_flag_q, zero_flag_q;
    logic              carry_nxt, last_word, res_zero;
    logic [WORD_W-1:0] cur_a, cur_b;

    assign op_in      = '{sel: op_select, mode: op_mode};
    assign cur_a      = a_q[idx_q];
    assign cur_b      = b_q[idx_q];
    assign last_word  = (CNT_W'(idx_q) == (n_q - CNT_W'(1)));
    assign res_zero   = (alu_result == '0);
    assign result     = res_q;
    assign carry_flag = carry_flag_q;
    assign zero_flag  = zero_flag_q;

    // Effective word count: 0 means one word, oversize clamps to WORDS
    always_comb begin
        n_eff = num_words;
        if (num_words == '0)
            n_eff = CNT_W'(1);
        else if (num_words > CNT_W'(WORDS))
            n_eff = CNT_W'(WORDS);
    end

    alu_chain_carry u_chain (
        .a         (cur_a),
        .b         (cur_b),
        .carry     (carry_q),
        .op        (op_q),
        .carry_nxt (carry_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and ALU drive; ALU inputs are quiet outside RUN
    always_comb begin
        state_nxt    = state;
        alu_in_a     = '0;
        alu_in_b     = '0;
        alu_carry_in = 1'b0;
        alu_select   = '0;
        alu_mode     = 1'b0;
        busy         = (state != IDLE);
        done         = (state == DONE);
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                alu_in_a     = cur_a;
                alu_in_b     = cur_b;
                alu_carry_in = is_chain(op_q) ? carry_q : 1'b0;
                alu_select   = op_q.sel;
                alu_mode     = op_q.mode;
                if (last_word) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-word result collection and flag accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            op_q         <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            zacc_q       <= 1'b0;
            carry_flag_q <= 1'b0;
            zero_flag_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q          <= op_a;
                    b_q          <= op_b;
                    op_q         <= op_in;
                    n_q          <= n_eff;
                    idx_q        <= '0;
                    res_q        <= '0;
                    carry_q      <= is_chain(op_in) ? op_cin : 1'b0;
                    zacc_q       <= 1'b1;
                    carry_flag_q <= 1'b0;
                    zero_flag_q  <= 1'b0;
                end
                RUN: begin
                    res_q[idx_q] <= alu_result;
                    zacc_q       <= zacc_q & res_zero;
                    carry_q      <= carry_nxt;
                    idx_q        <= idx_q + IDX_W'(1);
                    if (last_word) begin
                        carry_flag_q <= carry_nxt;
                        zero_flag_q  <= zacc_q & res_zero;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench: behavioural 16-bit ALU around the sequencer, hand-computed vectors.
module tb_alu_word_sequencer;
    import alu_pkg::*;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] op_a = '0, op_b = '0;
    logic [3:0]  op_select = '0;
    logic        op_mode = 1'b0, op_cin = 1'b0;
    logic [2:0]  num_words = '0;
    logic [15:0] alu_in_a, alu_in_b, alu_result;
    logic        alu_carry_in, alu_mode;
    logic [3:0]  alu_select;
    logic        busy, done, carry_flag, zero_flag;
    logic [63:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    alu_word_sequencer #(.WORDS(WORDS), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .op_select(op_select), .op_mode(op_mode), .op_cin(op_cin),
        .num_words(num_words), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_carry_in(alu_carry_in), .alu_select(alu_select), .alu_mode(alu_mode),
        .alu_result(alu_result), .busy(busy), .done(done), .result(result),
        .carry_flag(carry_flag), .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    // Reference 16-bit ALU (combinational)
    always_comb begin
        alu_result = '0;
        if (alu_mode == MODE_ARITH) begin
            case (alu_select)
                SEL_ADD: alu_result = alu_in_a + alu_in_b + {15'b0, alu_carry_in};
                SEL_SUB: alu_result = alu_in_a - alu_in_b - {15'b0, alu_carry_in};
                SEL_SHL: alu_result = alu_in_a << 1;
                SEL_SHR: alu_result = alu_in_a >> 1;
                default: alu_result = alu_in_a;
            endcase
        end else begin
            case (alu_select)
                4'b0000, SEL_AND: alu_result = alu_in_a & alu_in_b;
                SEL_OR:           alu_result = alu_in_a | alu_in_b;
                SEL_XOR:          alu_result = alu_in_a ^ alu_in_b;
                SEL_NOTA:         alu_result = ~alu_in_a;
                SEL_NOTB:         alu_result = ~alu_in_b;
                SEL_PASSA:        alu_result = alu_in_a;
                SEL_PASSB:        alu_result = alu_in_b;
                default:          alu_result = '0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Run one operation; samples on negedges. When hold=1, start stays high
    // through the whole operation, the DONE cycle and the IDLE edge after it.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] sel, input logic mode, input logic cin,
                          input logic [2:0] nw, input bit hold,
                          input logic [63:0] exp_res, input logic exp_cf, input logic exp_zf,
                          input int exp_lat);
        int lat = -1;
        int bcnt = 0;
        bit cin_seen = 1'b0;
        logic [63:0] r = '0;
        logic cf = 1'b0, zf = 1'b0;
        @(negedge clk);
        op_a = a; op_b = b; op_select = sel; op_mode = mode; op_cin = cin;
        num_words = nw; start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (busy) bcnt++;
            if (alu_carry_in) cin_seen = 1'b1;
            if (done) begin
                lat = c; r = result; cf = carry_flag; zf = zero_flag;
                break;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy cycles"}, 64'(bcnt), 64'(exp_lat + 1));
        chk({tag, " result"}, r, exp_res);
        chk({tag, " carry_flag"}, {63'b0, cf}, {63'b0, exp_cf});
        chk({tag, " zero_flag"}, {63'b0, zf}, {63'b0, exp_zf});
        if (!is_chain('{sel: sel, mode: mode}))
            chk({tag, " alu_carry_in quiet"}, {63'b0, cin_seen}, 64'b0);
        @(negedge clk);
        chk({tag, " idle busy"}, {62'b0, busy, done}, 64'b0);
        start = 1'b0;
        @(negedge clk);
        chk({tag, " no restart"}, {62'b0, busy, done}, 64'b0);
        chk({tag, " result held"}, result, exp_res);
    endtask

    initial begin
        #12;
        chk("reset outs", {busy, done, carry_flag, zero_flag, alu_carry_in, alu_mode, alu_select},
            '0);
        chk("reset result", result, '0);
        chk("reset alu_in", {32'b0, alu_in_a, alu_in_b}, '0);
        @(negedge clk); rst_n = 1'b1;

        run_op("add carry16", 64'h0000_FFFF, 64'h1, SEL_ADD, MODE_ARITH, 1'b0, 3'd2, 1'b0,
               64'h0001_0000, 1'b0, 1'b0, 2);
        run_op("add wrap", 64'hFFFF_FFFF, 64'h1, SEL_ADD, MODE_ARITH, 1'b0, 3'd2, 1'b0,
               64'h0, 1'b1, 1'b1, 2);
        run_op("sub borrow", 64'h0001_0000, 64'h1, SEL_SUB, MODE_ARITH, 1'b0, 3'd2, 1'b0,
               64'h0000_FFFF, 1'b0, 1'b0, 2);
        run_op("sub under", 64'h0, 64'h1, SEL_SUB, MODE_ARITH, 1'b0, 3'd2, 1'b0,
               64'hFFFF_FFFF, 1'b1, 1'b0, 2);
        run_op("sub equal", 64'h0005_0000, 64'h0005_0001, SEL_SUB, MODE_ARITH, 1'b0, 3'd2, 1'b0,
               64'hFFFF_FFFF, 1'b1, 1'b0, 2);
        run_op("and4", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_0000_FFFF_0000, 4'b0000, MODE_LOGIC,
               1'b1, 3'd4, 1'b0, 64'hF0F0_0000_F0F0_0000, 1'b0, 1'b0, 4);
        run_op("shl", 64'h8000_8001, 64'h0, SEL_SHL, MODE_ARITH, 1'b1, 3'd2, 1'b0,
               64'h0000_0002, 1'b0, 1'b0, 2);
        run_op("nw0 hold", 64'h0005_0003, 64'h0007_0009, SEL_ADD, MODE_ARITH, 1'b0, 3'd0, 1'b1,
               64'h0000_000C, 1'b0, 1'b0, 1);
        run_op("nw5 hold", 64'h0001_0002_0003_FFFF, 64'h0001_0001_0001_0001, SEL_ADD,
               MODE_ARITH, 1'b0, 3'd5, 1'b1, 64'h0002_0003_0005_0000, 1'b0, 1'b0, 4);

        // Reset while processing word 1 aborts with no done pulse
        @(negedge clk);
        op_a = 64'h1111_2222_3333_4444; op_b = 64'h1; op_select = SEL_ADD;
        op_mode = MODE_ARITH; op_cin = 1'b0; num_words = 3'd4; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("pre-abort word1 drive", {48'b0, alu_in_a}, 64'h3333);
        rst_n = 1'b0;
        #1;
        chk("abort outs", {busy, done, carry_flag, zero_flag, alu_carry_in, alu_mode, alu_select},
            '0);
        chk("abort result", result, '0);
        chk("abort alu_in", {32'b0, alu_in_a, alu_in_b}, '0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("abort no done", {62'b0, busy, done}, 64'b0);

        run_op("xor3 post-reset", 64'hFFFF_1234_5678_9ABC, 64'hFFFF_1234_0000_FFFF, SEL_XOR,
               MODE_LOGIC, 1'b0, 3'd3, 1'b0, 64'h0000_0000_5678_6543, 1'b0, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
